// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline enable/flush control for accumulator RAW hazards, taken branches and
// memory waits, with saturating stall and flush event counters.
module pipe_ctrl #(
   parameter int STALL_CNT_W = 16,
   parameter int FLUSH_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   iValid_ID,
   input  logic                   iReadA_ID,
   input  logic                   iReadB_ID,
   input  logic                   iWriteA_ID,
   input  logic                   iWriteB_ID,
   input  logic                   iBrTaken_EX,
   input  logic                   iMemBusy,
   output logic                   oEn_IF_ID,
   output logic                   oEn_ID_EX,
   output logic                   oEn_EX_MEM,
   output logic                   oEn_MEM_WB,
   output logic                   oFlush_IF_ID,
   output logic                   oFlush_ID_EX,
   output logic                   oPcHold,
   output logic [STALL_CNT_W-1:0] oStallCnt,
   output logic [FLUSH_CNT_W-1:0] oFlushCnt,
   output logic [1:0]             oState
);
   typedef enum logic [1:0] {RUN = 2'd0, RAW = 2'd1, MEMW = 2'd2} state_t;
   state_t state, nextState;
   logic [2:0] pendA, pendB;
   logic brPend, hazard, flush, stall, issA, issB;

   assign hazard = iValid_ID & ((iReadA_ID & |pendA) | (iReadB_ID & |pendB));
   // A branch seen during a memory wait is replayed from brPend once MEM frees up
   assign flush  = ~iMemBusy & (brPend | iBrTaken_EX);
   assign stall  = ~iMemBusy & ~flush & hazard;
   assign issA   = ~flush & ~stall & iValid_ID & iWriteA_ID;
   assign issB   = ~flush & ~stall & iValid_ID & iWriteB_ID;

   assign oEn_IF_ID    = reset & ~iMemBusy & ~stall;
   assign oEn_ID_EX    = reset & ~iMemBusy;
   assign oEn_EX_MEM   = reset & ~iMemBusy;
   assign oEn_MEM_WB   = reset & ~iMemBusy;
   assign oFlush_IF_ID = ~reset | flush;
   assign oFlush_ID_EX = ~reset | flush | stall;
   assign oPcHold      = ~reset | iMemBusy | stall;
   assign oState       = state;

   always_comb begin
      nextState = iMemBusy ? MEMW : stall ? RAW : RUN;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= RUN;
         pendA     <= '0;
         pendB     <= '0;
         brPend    <= 1'b0;
         oStallCnt <= '0;
         oFlushCnt <= '0;
      end else begin
         state <= nextState;
         if (!iMemBusy) begin
            pendA <= {pendA[1:0], issA};
            pendB <= {pendB[1:0], issB};
         end
         brPend <= iMemBusy & (brPend | iBrTaken_EX);
         if (stall && !(&oStallCnt)) oStallCnt <= oStallCnt + 1'b1;
         if (flush && !(&oFlushCnt)) oFlushCnt <= oFlushCnt + 1'b1;
      end
   end
endmodule
